// File: rtl/axi4_lite_arbiter.sv
// Two-master to one-slave AXI4-Lite arbiter, independent round-robin read/write paths; AXI_ARB_STATS_EN adds grant counters.
// Latency: one registered arbitration cycle in IDLE, then pass-through muxing until the response handshake.
// Backpressure: slave READY/VALID is routed only to the granted master; the other master's requests stay pending.
module axi4_lite_arbiter #(
  parameter int Addr_Width = 32,
  parameter int Data_Width = 32,
  parameter int CNT_W      = 16
) (
  input  logic                    aclk,
  input  logic                    areset,
`ifdef AXI_ARB_STATS_EN
  output logic [CNT_W-1:0]        wr_gnt_cnt0,
  output logic [CNT_W-1:0]        wr_gnt_cnt1,
  output logic [CNT_W-1:0]        rd_gnt_cnt0,
  output logic [CNT_W-1:0]        rd_gnt_cnt1,
`endif
  input  logic [Addr_Width-1:0]   m0_awaddr,
  input  logic                    m0_awvalid,
  output logic                    m0_awready,
  input  logic [Data_Width-1:0]   m0_wdata,
  input  logic [Data_Width/8-1:0] m0_wstrb,
  input  logic                    m0_wvalid,
  output logic                    m0_wready,
  output logic [1:0]              m0_bresp,
  output logic                    m0_bvalid,
  input  logic                    m0_bready,
  input  logic [Addr_Width-1:0]   m0_araddr,
  input  logic                    m0_arvalid,
  output logic                    m0_arready,
  output logic [Data_Width-1:0]   m0_rdata,
  output logic [1:0]              m0_rresp,
  output logic                    m0_rvalid,
  input  logic                    m0_rready,
  input  logic [Addr_Width-1:0]   m1_awaddr,
  input  logic                    m1_awvalid,
  output logic                    m1_awready,
  input  logic [Data_Width-1:0]   m1_wdata,
  input  logic [Data_Width/8-1:0] m1_wstrb,
  input  logic                    m1_wvalid,
  output logic                    m1_wready,
  output logic [1:0]              m1_bresp,
  output logic                    m1_bvalid,
  input  logic                    m1_bready,
  input  logic [Addr_Width-1:0]   m1_araddr,
  input  logic                    m1_arvalid,
  output logic                    m1_arready,
  output logic [Data_Width-1:0]   m1_rdata,
  output logic [1:0]              m1_rresp,
  output logic                    m1_rvalid,
  input  logic                    m1_rready,
  output logic [Addr_Width-1:0]   s_awaddr,
  output logic                    s_awvalid,
  input  logic                    s_awready,
  output logic [Data_Width-1:0]   s_wdata,
  output logic [Data_Width/8-1:0] s_wstrb,
  output logic                    s_wvalid,
  input  logic                    s_wready,
  input  logic [1:0]              s_bresp,
  input  logic                    s_bvalid,
  output logic                    s_bready,
  output logic [Addr_Width-1:0]   s_araddr,
  output logic                    s_arvalid,
  input  logic                    s_arready,
  input  logic [Data_Width-1:0]   s_rdata,
  input  logic [1:0]              s_rresp,
  input  logic                    s_rvalid,
  output logic                    s_rready
);

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_RESP} r_state_t;

  w_state_t w_state;
  r_state_t r_state;
  logic     w_gnt, wr_last, aw_done, w_done;
  logic     r_gnt, rd_last;
  logic     aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic     wa0, wa1, wb0, wb1, ra0, ra1, rb0, rb1;

  assign wa0 = (w_state == W_ADDR) && !w_gnt;
  assign wa1 = (w_state == W_ADDR) &&  w_gnt;
  assign wb0 = (w_state == W_RESP) && !w_gnt;
  assign wb1 = (w_state == W_RESP) &&  w_gnt;
  assign ra0 = (r_state == R_ADDR) && !r_gnt;
  assign ra1 = (r_state == R_ADDR) &&  r_gnt;
  assign rb0 = (r_state == R_RESP) && !r_gnt;
  assign rb1 = (r_state == R_RESP) &&  r_gnt;

  // Slave-side request path; a channel's VALID is masked once its handshake is done.
  assign s_awaddr  = w_gnt ? m1_awaddr : m0_awaddr;
  assign s_wdata   = w_gnt ? m1_wdata  : m0_wdata;
  assign s_wstrb   = w_gnt ? m1_wstrb  : m0_wstrb;
  assign s_awvalid = (wa0 && m0_awvalid || wa1 && m1_awvalid) && !aw_done;
  assign s_wvalid  = (wa0 && m0_wvalid  || wa1 && m1_wvalid)  && !w_done;
  assign s_bready  = wb0 && m0_bready || wb1 && m1_bready;
  assign s_araddr  = r_gnt ? m1_araddr : m0_araddr;
  assign s_arvalid = ra0 && m0_arvalid || ra1 && m1_arvalid;
  assign s_rready  = rb0 && m0_rready || rb1 && m1_rready;

  assign aw_hs = s_awvalid && s_awready;
  assign w_hs  = s_wvalid  && s_wready;
  assign b_hs  = s_bvalid  && s_bready;
  assign ar_hs = s_arvalid && s_arready;
  assign r_hs  = s_rvalid  && s_rready;

  // Master-side returns depend only on registered state and slave signals.
  assign m0_awready = wa0 && !aw_done && s_awready;
  assign m1_awready = wa1 && !aw_done && s_awready;
  assign m0_wready  = wa0 && !w_done && s_wready;
  assign m1_wready  = wa1 && !w_done && s_wready;
  assign m0_bvalid  = wb0 && s_bvalid;
  assign m1_bvalid  = wb1 && s_bvalid;
  assign m0_bresp   = wb0 ? s_bresp : 2'b00;
  assign m1_bresp   = wb1 ? s_bresp : 2'b00;
  assign m0_arready = ra0 && s_arready;
  assign m1_arready = ra1 && s_arready;
  assign m0_rvalid  = rb0 && s_rvalid;
  assign m1_rvalid  = rb1 && s_rvalid;
  assign m0_rdata   = rb0 ? s_rdata : '0;
  assign m1_rdata   = rb1 ? s_rdata : '0;
  assign m0_rresp   = rb0 ? s_rresp : 2'b00;
  assign m1_rresp   = rb1 ? s_rresp : 2'b00;

  always_ff @(posedge aclk) begin
    if (areset) begin
      w_state <= W_IDLE;
      w_gnt   <= 1'b0;
      wr_last <= 1'b1;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: if (m0_awvalid || m1_awvalid) begin
          w_gnt   <= (m0_awvalid && m1_awvalid) ? !wr_last : m1_awvalid;
          w_state <= W_ADDR;
        end
        W_ADDR: if ((aw_done || aw_hs) && (w_done || w_hs)) begin
          aw_done <= 1'b0;
          w_done  <= 1'b0;
          w_state <= W_RESP;
        end else begin
          if (aw_hs) aw_done <= 1'b1;
          if (w_hs)  w_done  <= 1'b1;
        end
        W_RESP: if (b_hs) begin
          wr_last <= w_gnt;
          w_state <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state <= R_IDLE;
      r_gnt   <= 1'b0;
      rd_last <= 1'b1;
    end else begin
      case (r_state)
        R_IDLE: if (m0_arvalid || m1_arvalid) begin
          r_gnt   <= (m0_arvalid && m1_arvalid) ? !rd_last : m1_arvalid;
          r_state <= R_ADDR;
        end
        R_ADDR: if (ar_hs) r_state <= R_RESP;
        R_RESP: if (r_hs) begin
          rd_last <= r_gnt;
          r_state <= R_IDLE;
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

`ifdef AXI_ARB_STATS_EN
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_gnt_cnt0 <= '0;
      wr_gnt_cnt1 <= '0;
      rd_gnt_cnt0 <= '0;
      rd_gnt_cnt1 <= '0;
    end else begin
      if (b_hs && !w_gnt && !(&wr_gnt_cnt0)) wr_gnt_cnt0 <= wr_gnt_cnt0 + CNT_ONE;
      if (b_hs &&  w_gnt && !(&wr_gnt_cnt1)) wr_gnt_cnt1 <= wr_gnt_cnt1 + CNT_ONE;
      if (r_hs && !r_gnt && !(&rd_gnt_cnt0)) rd_gnt_cnt0 <= rd_gnt_cnt0 + CNT_ONE;
      if (r_hs &&  r_gnt && !(&rd_gnt_cnt1)) rd_gnt_cnt1 <= rd_gnt_cnt1 + CNT_ONE;
    end
  end
`endif

endmodule

// File: tb/tb_axi4_lite_arbiter.sv
// Bench for axi4_lite_arbiter: directed scenarios plus randomized traffic against a transaction-level model,
// with a behavioural memory slave on the downstream port.
module tb_axi4_lite_arbiter;

  localparam int TB_CNT_W = 2;

  logic aclk = 1'b0;
  logic areset = 1'b1;
  always #5 aclk = ~aclk;

  logic [31:0] m_awaddr [2];
  logic [31:0] m_wdata  [2];
  logic [3:0]  m_wstrb  [2];
  logic [31:0] m_araddr [2];
  logic [31:0] m_rdata  [2];
  logic [1:0]  m_bresp  [2];
  logic [1:0]  m_rresp  [2];
  logic [1:0]  m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [1:0]  m_arvalid, m_arready, m_rvalid, m_rready;

  logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
  logic [3:0]  s_wstrb;
  logic [1:0]  s_bresp, s_rresp;
  logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic        s_arvalid, s_arready, s_rvalid, s_rready;

`ifdef AXI_ARB_STATS_EN
  logic [TB_CNT_W-1:0] wr_gnt_cnt0, wr_gnt_cnt1, rd_gnt_cnt0, rd_gnt_cnt1;
  int mw [2];
  int mr [2];
`endif

  axi4_lite_arbiter #(.Addr_Width(32), .Data_Width(32), .CNT_W(TB_CNT_W)) dut (
    .aclk(aclk), .areset(areset),
`ifdef AXI_ARB_STATS_EN
    .wr_gnt_cnt0(wr_gnt_cnt0), .wr_gnt_cnt1(wr_gnt_cnt1),
    .rd_gnt_cnt0(rd_gnt_cnt0), .rd_gnt_cnt1(rd_gnt_cnt1),
`endif
    .m0_awaddr(m_awaddr[0]), .m0_awvalid(m_awvalid[0]), .m0_awready(m_awready[0]),
    .m0_wdata(m_wdata[0]), .m0_wstrb(m_wstrb[0]), .m0_wvalid(m_wvalid[0]), .m0_wready(m_wready[0]),
    .m0_bresp(m_bresp[0]), .m0_bvalid(m_bvalid[0]), .m0_bready(m_bready[0]),
    .m0_araddr(m_araddr[0]), .m0_arvalid(m_arvalid[0]), .m0_arready(m_arready[0]),
    .m0_rdata(m_rdata[0]), .m0_rresp(m_rresp[0]), .m0_rvalid(m_rvalid[0]), .m0_rready(m_rready[0]),
    .m1_awaddr(m_awaddr[1]), .m1_awvalid(m_awvalid[1]), .m1_awready(m_awready[1]),
    .m1_wdata(m_wdata[1]), .m1_wstrb(m_wstrb[1]), .m1_wvalid(m_wvalid[1]), .m1_wready(m_wready[1]),
    .m1_bresp(m_bresp[1]), .m1_bvalid(m_bvalid[1]), .m1_bready(m_bready[1]),
    .m1_araddr(m_araddr[1]), .m1_arvalid(m_arvalid[1]), .m1_arready(m_arready[1]),
    .m1_rdata(m_rdata[1]), .m1_rresp(m_rresp[1]), .m1_rvalid(m_rvalid[1]), .m1_rready(m_rready[1]),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int prot_err = 0;
  int act1     = 0;
  int model_wr_last, model_rd_last;
  logic [31:0] model_mem [logic [31:0]];
  logic [31:0] smem      [logic [31:0]];
  logic [31:0] wlog [$];
  logic [31:0] rlog [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mexp(input logic [31:0] a);
    return model_mem.exists(a) ? model_mem[a] : 32'h0;
  endfunction

  // Round-robin rule: on a tie the master that did not win last time goes first.
  function automatic int pick(input int last, input bit r0, input bit r1);
    if (r0 && r1) return 1 - last;
    return r1 ? 1 : 0;
  endfunction

  // Behavioural memory slave: random READY, one response per accepted transaction.
  initial begin
    bit awh, wh, bh, arh, rh, got_aw, got_w;
    logic [31:0] aw_a, wd, ar_a;
    s_awready = 0; s_wready = 0; s_bvalid = 0; s_bresp = 0;
    s_arready = 0; s_rvalid = 0; s_rdata = 0; s_rresp = 0;
    got_aw = 0; got_w = 0; aw_a = 0; wd = 0; ar_a = 0;
    forever begin
      @(negedge aclk);
      if (|{m_awready[1], m_wready[1], m_bvalid[1], m_arready[1], m_rvalid[1]}) act1++;
      if (&m_awready || &m_wready || &m_bvalid || &m_arready || &m_rvalid) prot_err++;
      if (s_awvalid && (got_aw || s_bvalid)) prot_err++;
      if (s_wvalid && (got_w || s_bvalid || s_wstrb != 4'hF)) prot_err++;
      if (s_arvalid && s_rvalid) prot_err++;
      awh = s_awvalid && s_awready;
      wh  = s_wvalid && s_wready;
      bh  = s_bvalid && s_bready;
      arh = s_arvalid && s_arready;
      rh  = s_rvalid && s_rready;
      if (awh) aw_a = s_awaddr;
      if (wh)  wd = s_wdata;
      if (arh) ar_a = s_araddr;
      @(posedge aclk); #1;
      if (areset) begin
        s_awready = 0; s_wready = 0; s_bvalid = 0; s_arready = 0; s_rvalid = 0; s_rdata = 0;
        got_aw = 0; got_w = 0;
      end else begin
        if (awh) got_aw = 1;
        if (wh)  got_w = 1;
        if (bh)  s_bvalid = 0;
        if (rh)  s_rvalid = 0;
        if (got_aw && got_w && !s_bvalid) begin
          smem[aw_a] = wd; wlog.push_back(aw_a);
          s_bvalid = 1; got_aw = 0; got_w = 0;
        end
        if (arh) begin
          s_rdata = smem.exists(ar_a) ? smem[ar_a] : 32'h0;
          s_rvalid = 1; rlog.push_back(ar_a);
        end
        s_awready = !got_aw && !s_bvalid && ($urandom_range(0, 3) != 0);
        s_wready  = !got_w && !s_bvalid && ($urandom_range(0, 3) != 0);
        s_arready = !s_rvalid && ($urandom_range(0, 3) != 0);
      end
    end
  end

  task automatic do_write(input int m, input logic [31:0] addr, input logic [31:0] data,
                          input int w_lag, input bit hold_b);
    int cyc; bit awp, wp, early, ah, wh, h; logic [1:0] r;
    model_mem[addr] = data;
    m_awaddr[m] = addr; m_wdata[m] = data; m_wstrb[m] = 4'hF;
    m_awvalid[m] = 1; m_wvalid[m] = (w_lag == 0);
    awp = 1; wp = 1; early = 0; cyc = 0; r = 2'bxx;
    while ((awp || wp) && cyc < 200) begin
      @(negedge aclk);
      if (m_bvalid[m]) early = 1;
      ah = m_awvalid[m] && m_awready[m];
      wh = m_wvalid[m] && m_wready[m];
      @(posedge aclk); #1; cyc++;
      if (ah) begin awp = 0; m_awvalid[m] = 0; end
      if (wh) begin wp = 0; m_wvalid[m] = 0; end
      if (wp && cyc >= w_lag) m_wvalid[m] = 1;
    end
    m_awvalid[m] = 0; m_wvalid[m] = 0;
    check("aw_w_timeout", {63'b0, !(awp || wp)}, 64'd1);
    check("b_before_addr", {63'b0, early}, 64'd0);
    m_bready[m] = !hold_b; h = 0; cyc = 0;
    while (!h && cyc < 200) begin
      @(negedge aclk);
      h = m_bvalid[m]; r = m_bresp[m];
      @(posedge aclk); #1; cyc++;
    end
    m_bready[m] = 0;
    check("b_timeout", {63'b0, h}, 64'd1);
    check("bresp", {62'b0, r}, 64'd0);
`ifdef AXI_ARB_STATS_EN
    if (!hold_b && mw[m] < 2**TB_CNT_W - 1) mw[m]++;
`endif
  endtask

  task automatic do_read(input int m, input logic [31:0] addr, input logic [31:0] exp);
    int cyc; bit h; logic [31:0] d; logic [1:0] r;
    m_araddr[m] = addr; m_arvalid[m] = 1; h = 0; cyc = 0; d = 'x; r = 'x;
    while (!h && cyc < 200) begin
      @(negedge aclk); h = m_arready[m];
      @(posedge aclk); #1; cyc++;
    end
    m_arvalid[m] = 0;
    check("ar_timeout", {63'b0, h}, 64'd1);
    m_rready[m] = 1; h = 0; cyc = 0;
    while (!h && cyc < 200) begin
      @(negedge aclk); h = m_rvalid[m]; d = m_rdata[m]; r = m_rresp[m];
      @(posedge aclk); #1; cyc++;
    end
    m_rready[m] = 0;
    check("r_timeout", {63'b0, h}, 64'd1);
    check("rdata", {32'b0, d}, {32'b0, exp});
    check("rresp", {62'b0, r}, 64'd0);
`ifdef AXI_ARB_STATS_EN
    if (mr[m] < 2**TB_CNT_W - 1) mr[m]++;
`endif
  endtask

  task automatic pulse_reset(input string tag);
    @(negedge aclk); areset = 1;
    @(posedge aclk); @(negedge aclk);
    check({tag, "_ctrl"}, {49'b0, m_awready, m_wready, m_bvalid, m_arready, m_rvalid,
                           s_awvalid, s_wvalid, s_arvalid, s_bready, s_rready}, 64'd0);
    check({tag, "_data"}, {24'b0, m_rdata[0] | m_rdata[1], m_bresp[0], m_bresp[1],
                           m_rresp[0], m_rresp[1]}, 64'd0);
    @(posedge aclk); @(negedge aclk); areset = 0;
    model_wr_last = 1; model_rd_last = 1;
`ifdef AXI_ARB_STATS_EN
    mw[0] = 0; mw[1] = 0; mr[0] = 0; mr[1] = 0;
`endif
  endtask

  initial begin
    int base, e, last, rem0, rem1, a1base, k;
    logic [31:0] a0, a1, d0, d1;
    bit op0, op1;
    for (int i = 0; i < 2; i++) begin
      m_awaddr[i] = 0; m_wdata[i] = 0; m_wstrb[i] = 0; m_araddr[i] = 0;
    end
    m_awvalid = 0; m_wvalid = 0; m_bready = 0; m_arvalid = 0; m_rready = 0;

    pulse_reset("por");

    // Single master write then read; master 1 must see nothing.
    a1base = act1;
    do_write(0, 32'h004, 32'hDEADBEEF, 0, 0);
    do_read(0, 32'h004, 32'hDEADBEEF);
    check("m1_quiet", act1 - a1base, 0);

    // Simultaneous writes straight out of reset.
    pulse_reset("rst2");
    base = wlog.size();
    e = pick(model_wr_last, 1, 1);
    fork
      do_write(0, 32'h008, 32'h11, 0, 0);
      do_write(1, 32'h00C, 32'h22, 0, 0);
    join
    model_wr_last = 1 - e;
    check("sim_wr_count", wlog.size() - base, 2);
    if (wlog.size() - base == 2) begin
      check("sim_wr_first", {32'b0, wlog[base]}, (e == 0) ? 64'h008 : 64'h00C);
      check("sim_wr_second", {32'b0, wlog[base + 1]}, (e == 0) ? 64'h00C : 64'h008);
    end
    do_read(0, 32'h008, 32'h11);
    do_read(1, 32'h00C, 32'h22);
    model_rd_last = 1;

    // Fairness: six back-to-back reads from each master.
    for (int i = 0; i < 6; i++) do_write(0, 32'h100 + 4 * i, $urandom, 0, 0);
    for (int i = 0; i < 6; i++) do_write(1, 32'h200 + 4 * i, $urandom, 0, 0);
    model_wr_last = 1;
    base = rlog.size();
    fork
      for (int i = 0; i < 6; i++) do_read(0, 32'h100 + 4 * i, mexp(32'h100 + 4 * i));
      for (int i = 0; i < 6; i++) do_read(1, 32'h200 + 4 * i, mexp(32'h200 + 4 * i));
    join
    check("fair_count", rlog.size() - base, 12);
    last = model_rd_last; rem0 = 6; rem1 = 6;
    for (int i = 0; i < 12; i++) begin
      e = pick(last, rem0 > 0, rem1 > 0);
      if (base + i < rlog.size())
        check("fair_order", (rlog[base + i] >= 32'h200) ? 64'd1 : 64'd0, e);
      last = e;
      if (e == 0) rem0--; else rem1--;
    end
    model_rd_last = last;

    // Overlapped write (W lags AW by 3 cycles) and read on different masters.
    d0 = $urandom;
    fork
      do_write(0, 32'h030, d0, 3, 0);
      do_read(1, 32'h004, 32'hDEADBEEF);
    join
    do_read(0, 32'h030, d0);

    // Randomized concurrent traffic in disjoint address regions.
    for (k = 0; k < 20; k++) begin
      a0 = 32'h400 + 8 * $urandom_range(0, 7);
      a1 = 32'h404 + 8 * $urandom_range(0, 7);
      d0 = $urandom; d1 = $urandom;
      op0 = $urandom_range(0, 1) == 1; op1 = $urandom_range(0, 1) == 1;
      fork
        if (op0) do_write(0, a0, d0, $urandom_range(0, 3), 0); else do_read(0, a0, mexp(a0));
        if (op1) do_write(1, a1, d1, $urandom_range(0, 3), 0); else do_read(1, a1, mexp(a1));
      join
    end

    // Reset while master 0 waits in the response phase.
    do_write(0, 32'h020, 32'h5A5A5A5A, 0, 1);
    pulse_reset("rst_mid");
    d1 = $urandom;
    do_write(1, 32'h010, d1, 0, 0);
    do_read(1, 32'h010, d1);

`ifdef AXI_ARB_STATS_EN
    pulse_reset("rst_stats");
    check("cnt_rst", {wr_gnt_cnt0, wr_gnt_cnt1, rd_gnt_cnt0, rd_gnt_cnt1}, 64'd0);
    for (int i = 0; i < 3; i++) do_write(0, 32'h040 + 4 * i, $urandom, 0, 0);
    for (int i = 0; i < 2; i++) do_read(1, 32'h040 + 4 * i, mexp(32'h040 + 4 * i));
    @(negedge aclk);
    check("wr_cnt0", wr_gnt_cnt0, mw[0]);
    check("wr_cnt1", wr_gnt_cnt1, mw[1]);
    check("rd_cnt0", rd_gnt_cnt0, mr[0]);
    check("rd_cnt1", rd_gnt_cnt1, mr[1]);
    for (int i = 0; i < 2; i++) do_write(0, 32'h050 + 4 * i, $urandom, 0, 0);
    @(negedge aclk);
    check("wr_cnt0_sat", wr_gnt_cnt0, mw[0]);
`endif

    check("one_txn_at_a_time", prot_err, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/axi4_lite_arbiter.md
Name: axi4_lite_arbiter

Overview:
- Two-master to one-slave AXI4-Lite arbiter that sits between two bus masters and the single axi4_lite_slave memory.
- Read and write paths are arbitrated independently, each with round-robin priority.
- A grant is held from the address handshake through the response handshake, so each slave FSM sees exactly one transaction at a time.
- Single clock domain; arbitration decision is registered.

Parameters:
- Addr_Width, 32, address width carried through the muxes (matches axi4_lite_Defs).
- Data_Width, 32, read/write data width (matches axi4_lite_Defs).
- CNT_W, 16, width of the optional grant counters.

Ports:
- ACLK  input  1  clock; all logic is on the rising edge.
- ARESET  input  1  synchronous, active-high reset.
- M0  axi4_lite_if.slave_if  bundle  upstream master 0; arbiter acts as its slave.
- M1  axi4_lite_if.slave_if  bundle  upstream master 1.
- S  axi4_lite_if.master_if  bundle  downstream port to axi4_lite_slave.
- Interface-internal clock/reset signals are ignored; ACLK/ARESET govern.

Behaviour:
- Reset (ARESET=1 sampled at a rising edge):
  - Both FSMs go to IDLE; wr_last and rd_last reset to 1, so M0 wins the first tie.
  - All outputs 0 from the following cycle: M*.AWREADY/WREADY/BVALID/ARREADY/RVALID, M*.RDATA, M*.BRESP/RRESP, S.AWVALID/WVALID/ARVALID/BREADY/RREADY.
  - Reset mid-transaction abandons the transaction; no replay.
- Write FSM, states W_IDLE -> W_ADDR -> W_RESP -> W_IDLE:
  - W_IDLE: request_i = Mi.AWVALID. If exactly one requests, grant it. If both request, grant the master != wr_last. Grant index is registered; move to W_ADDR next cycle. One cycle arbitration latency, and no slave-side valid in W_IDLE.
  - W_ADDR: S.AW*/W* are driven from the granted master; S.AWREADY/WREADY are returned only to the granted master.
  - W_ADDR: sticky flags aw_done/w_done are set on each handshake, and a channel's VALID is gated to the slave once its flag is set. Leave when both flags are set (same-cycle handshakes allowed) and clear the flags.
  - W_RESP: S.BVALID/BRESP go to the granted master; S.BREADY = granted Mi.BREADY. On the B handshake: wr_last <= grant, go to W_IDLE.
- Read FSM, states R_IDLE -> R_ADDR -> R_RESP -> R_IDLE:
  - Same scheme keyed on Mi.ARVALID with rd_last.
  - R_ADDR routes AR until the AR handshake.
  - R_RESP routes RVALID/RDATA/RRESP and RREADY until the R handshake, then updates rd_last.
- Non-granted master: all its ready/valid inputs see 0, with RDATA=0 and B/RRESP=0. Its requests stay pending; they are never dropped or acknowledged.
- Read and write FSMs are fully concurrent: M0 may own the write path while M1 owns the read path.
- Request withdrawn in IDLE before the grant registers: the grant is still issued, and the arbiter waits in ADDR. Legal AXI masters do not withdraw VALID.
- Fairness: with both masters requesting continuously, grants alternate strictly 0,1,0,1.
- No combinational path from any Mi VALID to any Mi READY.

Optional Feature:
- Macro: AXI_ARB_STATS_EN.
- Defined: adds output ports wr_gnt_cnt0, wr_gnt_cnt1, rd_gnt_cnt0, rd_gnt_cnt1, each CNT_W bits.
  - Each counter increments by 1 on completion of a granted transaction (B or R handshake) for that master.
  - Counters saturate at all-ones and clear to 0 on ARESET.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset: hold ARESET 2 cycles during M0 write in W_RESP -> all outputs 0 next cycle, FSMs IDLE; a following M1 write to 0x10 completes normally.
- Single write then read: M0 writes 0xDEADBEEF to 0x004, then reads 0x004 -> M0.RDATA=0xDEADBEEF, RRESP=0. M1 sees no READY/VALID throughout.
- Simultaneous writes from idle reset: M0 to 0x008 = 0x11, M1 to 0x00C = 0x22 -> M0 granted first, M1 second. Slave shows exactly two sequential transactions, and later reads return 0x11 and 0x22.
- Fairness: both masters issue 6 back-to-back reads -> grant order 0,1,0,1,0,1,... with no master waiting more than one transaction.
- Concurrency, split AW/W: M0 write (AW 3 cycles before W) while M1 reads 0x004 -> both complete overlapped, and the write reaches W_RESP only after both handshakes.
- With AXI_ARB_STATS_EN: 3 M0 writes, 2 M1 reads -> wr_gnt_cnt0=3, wr_gnt_cnt1=0, rd_gnt_cnt0=0, rd_gnt_cnt1=2. With CNT_W=2 and 5 M0 writes -> wr_gnt_cnt0 saturates at 3.
